// File: rtl/pcpi_vector_unit.sv
// pcpi_vector_unit: PCPI coprocessor with a small vector register file.
// Handles vsetvl, element insert/extract, lane-parallel add/sub/mul and a
// sum reduction. Build option VPU_MUL_EN adds funct3=101 (VMUL, low 32 bits
// of the unsigned product); without it that encoding is rejected and no
// multiplier exists.
//
// state | meaning
// IDLE  | waiting for a supported custom-0 instruction
// EXEC  | working; vector ops take one element group per cycle
// DONE  | one-cycle completion, pcpi_ready asserted
module pcpi_vector_unit #(
    parameter int NUM_LANES  = 4,
    parameter int VREG_COUNT = 8,
    parameter int MAX_VL     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pcpi_valid,
    input  logic [31:0]              pcpi_insn,
    input  logic [31:0]              pcpi_rs1,
    input  logic [31:0]              pcpi_rs2,
    output logic                     pcpi_wr,
    output logic [31:0]              pcpi_rd,
    output logic                     pcpi_wait,
    output logic                     pcpi_ready,
    output logic [$clog2(MAX_VL):0]  vl
);
    localparam int VLW  = $clog2(MAX_VL) + 1;
    localparam int VLW1 = VLW + 1;
    localparam int IW   = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;
    localparam int RW   = $clog2(VREG_COUNT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_VSETVL  = 3'b000;
    localparam logic [2:0] OP_VINS    = 3'b001;
    localparam logic [2:0] OP_VEXT    = 3'b010;
    localparam logic [2:0] OP_VADD    = 3'b011;
    localparam logic [2:0] OP_VSUB    = 3'b100;
    localparam logic [2:0] OP_VMUL    = 3'b101;
    localparam logic [2:0] OP_VREDSUM = 3'b110;

    logic [31:0]    vreg_q [VREG_COUNT][MAX_VL];

    logic [1:0]     state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [RW-1:0]  vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [31:0]    rs1_q, rs1_d, acc_q, acc_d, rd_q, rd_d;
    logic [VLW-1:0] grp_q, grp_d, vl_q, vl_d;

    logic [2:0]     funct3;
    logic           op_ok, accept, last_grp, ins_we, vec_we;
    logic [VLW-1:0] lane_elem [NUM_LANES];
    logic [IW-1:0]  lane_idx  [NUM_LANES];
    logic [31:0]    lane_a    [NUM_LANES];
    logic [31:0]    lane_b    [NUM_LANES];
    logic [31:0]    lane_res  [NUM_LANES];
    logic [NUM_LANES-1:0] lane_act;
    logic [31:0]    lane_sum;
    logic           unused_insn;

    // The whole instruction word is accepted; only some fields are decoded.
    assign unused_insn = ^pcpi_insn;
    assign funct3      = pcpi_insn[14:12];

    // Supported-operation decode; VMUL only exists in the multiplier build.
    always_comb begin
        op_ok = 1'b0;
        case (funct3)
            OP_VSETVL, OP_VINS, OP_VEXT, OP_VADD, OP_VSUB, OP_VREDSUM: op_ok = 1'b1;
`ifdef VPU_MUL_EN
            OP_VMUL: op_ok = 1'b1;
`endif
            default: op_ok = 1'b0;
        endcase
    end

    assign accept   = (state_q == S_IDLE) && pcpi_valid &&
                      (pcpi_insn[6:0] == 7'b0001011) && op_ok;
    assign last_grp = ({1'b0, grp_q} + VLW1'(NUM_LANES)) >= {1'b0, vl_q};

    // Lane datapath: operands of the current element group and per-lane result.
    always_comb begin
        lane_act = '0;
        lane_sum = 32'd0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_elem[l] = grp_q + VLW'(l);
            lane_idx[l]  = lane_elem[l][IW-1:0];
            lane_act[l]  = lane_elem[l] < vl_q;
            lane_a[l]    = vreg_q[vs1_q][lane_idx[l]];
            lane_b[l]    = vreg_q[vs2_q][lane_idx[l]];
            case (op_q)
                OP_VSUB: lane_res[l] = lane_a[l] - lane_b[l];
`ifdef VPU_MUL_EN
                OP_VMUL: lane_res[l] = lane_a[l] * lane_b[l];
`endif
                default: lane_res[l] = lane_a[l] + lane_b[l];
            endcase
            lane_sum = lane_sum + (lane_act[l] ? lane_a[l] : 32'd0);
        end
    end

    // Next-state and operation sequencing.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vd_d    = vd_q;
        vs1_d   = vs1_q;
        vs2_d   = vs2_q;
        idx_d   = idx_q;
        rs1_d   = rs1_q;
        acc_d   = acc_q;
        rd_d    = rd_q;
        grp_d   = grp_q;
        vl_d    = vl_q;
        ins_we  = 1'b0;
        vec_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                    op_d    = funct3;
                    vd_d    = pcpi_insn[7 +: RW];
                    vs1_d   = pcpi_insn[15 +: RW];
                    vs2_d   = pcpi_insn[20 +: RW];
                    idx_d   = IW'(pcpi_rs2 % 32'(MAX_VL));
                    rs1_d   = pcpi_rs1;
                    acc_d   = 32'd0;
                    rd_d    = 32'd0;
                    grp_d   = '0;
                end
            end
            S_EXEC: begin
                // A dropped offer means the core gave up: leave without writing.
                if (!pcpi_valid) begin
                    state_d = S_IDLE;
                end else begin
                    case (op_q)
                        OP_VSETVL: begin
                            if (rs1_q > 32'(MAX_VL)) begin
                                vl_d = VLW'(MAX_VL);
                                rd_d = 32'(MAX_VL);
                            end else begin
                                vl_d = rs1_q[VLW-1:0];
                                rd_d = rs1_q;
                            end
                            state_d = S_DONE;
                        end
                        OP_VINS: begin
                            ins_we  = 1'b1;
                            state_d = S_DONE;
                        end
                        OP_VEXT: begin
                            rd_d    = vreg_q[vs1_q][idx_q];
                            state_d = S_DONE;
                        end
                        OP_VREDSUM: begin
                            acc_d = acc_q + lane_sum;
                            if (last_grp) begin
                                rd_d    = acc_q + lane_sum;
                                state_d = S_DONE;
                            end else begin
                                grp_d = grp_q + VLW'(NUM_LANES);
                            end
                        end
                        default: begin
                            vec_we = 1'b1;
                            if (last_grp) state_d = S_DONE;
                            else          grp_d   = grp_q + VLW'(NUM_LANES);
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_VSETVL;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            idx_q   <= '0;
            rs1_q   <= 32'd0;
            acc_q   <= 32'd0;
            rd_q    <= 32'd0;
            grp_q   <= '0;
            vl_q    <= VLW'(MAX_VL);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vd_q    <= vd_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            idx_q   <= idx_d;
            rs1_q   <= rs1_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            grp_q   <= grp_d;
            vl_q    <= vl_d;
        end
    end

    // Vector register file: not reset, writes suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (ins_we) vreg_q[vd_q][idx_q] <= rs1_q;
            if (vec_we) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (lane_act[l]) vreg_q[vd_q][lane_idx[l]] <= lane_res[l];
                end
            end
        end
    end

    assign pcpi_wait  = (state_q == S_EXEC) || (state_q == S_DONE);
    assign pcpi_ready = (state_q == S_DONE);
    assign pcpi_wr    = pcpi_ready &&
                        ((op_q == OP_VSETVL) || (op_q == OP_VEXT) || (op_q == OP_VREDSUM));
    assign pcpi_rd    = pcpi_wr ? rd_q : 32'd0;
    assign vl         = vl_q;
endmodule

// File: doc/pcpi_vector_unit.md
PCPI_VECTOR_UNIT -- requirements
Module: pcpi_vector_unit

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: elements processed per EXEC cycle; power of 2, 1..MAX_VL.
REQ-002 SHALL have parameter VREG_COUNT, default 8: vector registers; power of 2, 2..32.
REQ-003 SHALL have parameter MAX_VL, default 8: elements per vector register; power of 2, 32-bit elements.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 pcpi_valid  input  1  core instruction offer.
REQ-008 pcpi_insn  input  32  instruction word.
REQ-009 pcpi_rs1  input  32  scalar rs1 value.
REQ-010 pcpi_rs2  input  32  scalar rs2 value.
REQ-011 pcpi_wr  output  1  result write-back, valid with pcpi_ready.
REQ-012 pcpi_rd  output  32  scalar result, valid with pcpi_ready.
REQ-013 pcpi_wait  output  1  instruction accepted, unit busy.
REQ-014 pcpi_ready  output  1  one-cycle completion pulse.
REQ-015 vl  output  clog2(MAX_VL)+1  current vector length.

Function
REQ-016 SHALL accept only when state IDLE, pcpi_valid=1, pcpi_insn[6:0]=0001011 and funct3 (insn[14:12]) is a supported op; otherwise outputs stay idle.
REQ-017 Vector register indices SHALL be vd=insn[11:7], vs1=insn[19:15], vs2=insn[24:20], each truncated to log2(VREG_COUNT) bits; element index = pcpi_rs2 mod MAX_VL.
REQ-018 Ops: 000 VSETVL vl<=min(pcpi_rs1,MAX_VL), rd=new vl; 001 VINS vd[idx]<=pcpi_rs1; 010 VEXT rd=vs1[idx]; 011 VADD; 100 VSUB; 101 VMUL; 110 VREDSUM rd=sum of vs1[0..vl-1].
REQ-019 VADD/VSUB/VMUL SHALL compute vd[i]=vs1[i] op vs2[i] for i<vl, modulo 2^32; elements i>=vl unchanged; vd may alias vs1/vs2 (each element read before written).
REQ-020 FSM SHALL be IDLE->EXEC on accept, EXEC->DONE when the last element group is done, DONE->IDLE unconditionally.
REQ-021 pcpi_wait SHALL be 1 in EXEC and DONE; pcpi_ready 1 only in DONE.
REQ-022 pcpi_wr SHALL be 1 in DONE for VSETVL, VEXT, VREDSUM only; pcpi_rd 0 when pcpi_wr=0.
REQ-023 EXEC SHALL last 1 cycle for VSETVL/VINS/VEXT and max(1,ceil(vl/NUM_LANES)) cycles for vector ops, NUM_LANES elements per cycle; vl=0 writes nothing, VREDSUM returns 0.
REQ-024 VREDSUM SHALL accumulate NUM_LANES elements per cycle, wrapping modulo 2^32.
REQ-025 If pcpi_valid falls during EXEC (core timeout), SHALL return to IDLE next cycle without pcpi_ready; completed element writes remain.
REQ-026 pcpi_valid in DONE SHALL be ignored; unsupported funct3 or opcode SHALL never assert pcpi_wait.

Reset
REQ-027 reset=1 SHALL force state IDLE, vl=MAX_VL, pcpi_wr/pcpi_rd/pcpi_wait/pcpi_ready=0 next edge, aborting any operation with no further register writes.
REQ-028 Vector register contents SHALL NOT be reset.

Configuration
REQ-029 Macro VPU_MUL_EN defined: funct3=101 VMUL supported (low 32 bits of unsigned product), same latency as VADD.
REQ-030 VPU_MUL_EN undefined: funct3=101 unsupported per REQ-026; no multiplier instantiated.

Verification
REQ-031 Reset then VSETVL pcpi_rs1=20 -> pcpi_ready 2 cycles after accept, pcpi_wr=1, pcpi_rd=8, vl=8.
REQ-032 VINS v1[i]=i+1, v2[i]=0xFFFFFFFF (i=0..7), VADD v3=v1+v2, NUM_LANES=4 -> EXEC 2 cycles; VEXT v3[0]=0, v3[7]=7.
REQ-033 vl=5, VREDSUM v1 -> pcpi_rd=15, EXEC 2 cycles; v3[5..7] untouched by subsequent VSUB v3=v1-v1.
REQ-034 vl=0, VADD -> EXEC 1 cycle, ready pulse, pcpi_wr=0, no register changes.
REQ-035 reset asserted mid-VADD EXEC -> no pcpi_ready, state IDLE, vl=8; pcpi_valid dropped mid-EXEC -> IDLE, no ready.
REQ-036 funct3=101 with VPU_MUL_EN: 3*0x80000001 -> 0x80000003; without: pcpi_wait stays 0.
